// File: rtl/wb_regfile_pkg.sv
// Shared writeback/regfile definitions: status codes, icodes,
// register names and the RUN/HALT state type.
package wb_regfile_pkg;

  typedef enum logic [2:0] {
    BUB = 3'd0,
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fsm_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR8   = 4'h8;
  localparam logic [3:0] RR9   = 4'h9;
  localparam logic [3:0] RR10  = 4'hA;
  localparam logic [3:0] RR11  = 4'hB;
  localparam logic [3:0] RR12  = 4'hC;
  localparam logic [3:0] RR13  = 4'hD;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NREG = 15;

  function automatic logic is_stop(
    input logic [2:0] s
  );
    return (s == HLT) || (s == ADR) ||
           (s == INS);
  endfunction

endpackage

// File: rtl/wb_status_fsm.sv
// RUN/HALT tracker: registered status, halted flag,
// retired-instruction counter and the register write enable.
module wb_status_fsm
  import wb_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  w_stat,
  output logic        wr_en,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [63:0] retired
);

  fsm_e        state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [63:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stat_q    <= AOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    wr_en     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        wr_en = (w_stat == AOK);
        // HLT retires; faults and bubbles do not
        if (w_stat == AOK || w_stat == HLT)
          retired_d = retired_q + 64'd1;
        if (is_stop(w_stat)) begin
          state_d = ST_HALT;
          stat_d  = w_stat;
        end else if (w_stat == BUB) begin
          stat_d = AOK;
        end else begin
          stat_d = w_stat;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  assign stat    = stat_q;
  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 15 registers, two
// combinational read ports, two write ports gated by status.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    w_stat,
  input  logic [3:0]    w_icode,
  input  logic [3:0]    w_dstE,
  input  logic [3:0]    w_dstM,
  input  logic [DW-1:0] w_valE,
  input  logic [DW-1:0] w_valM,
  input  logic [3:0]    d_srcA,
  input  logic [3:0]    d_srcB,
  output logic [DW-1:0] d_rvalA,
  output logic [DW-1:0] d_rvalB,
  output logic [2:0]    stat,
  output logic          halted,
  output logic [63:0]   retired
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic          wr_en;
  logic          unused_icode;

  assign unused_icode = ^w_icode;

  wb_status_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_stat  (w_stat),
    .wr_en   (wr_en),
    .stat    (stat),
    .halted  (halted),
    .retired (retired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= rf_d[i];
    end
  end

  // M port applied last so it wins on equal dst (popq %rsp)
  always_comb begin
    for (int i = 0; i < NREG; i++)
      rf_d[i] = rf_q[i];
    if (wr_en) begin
      if (w_dstE != RNONE)
        rf_d[w_dstE] = w_valE;
      if (w_dstM != RNONE)
        rf_d[w_dstM] = w_valM;
    end
  end

  assign d_rvalA = (d_srcA == RNONE) ?
                   '0 : rf_q[d_srcA];
  assign d_rvalB = (d_srcB == RNONE) ?
                   '0 : rf_q[d_srcB];

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an
// array-based reference of the writeback rules.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  w_stat = 3'd0;
  logic [3:0]  w_icode = 4'h1;
  logic [3:0]  w_dstE = 4'hF;
  logic [3:0]  w_dstM = 4'hF;
  logic [63:0] w_valE = '0;
  logic [63:0] w_valM = '0;
  logic [3:0]  d_srcA = 4'hF;
  logic [3:0]  d_srcB = 4'hF;
  logic [63:0] d_rvalA, d_rvalB;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] retired;

  int nerr = 0;
  int nchk = 0;

  logic [63:0] mrf [16];
  logic        mhalt;
  logic [2:0]  mstat;
  logic [63:0] mret;

  always #5 clk = ~clk;

  wb_regfile #(.DW(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_stat  (w_stat),
    .w_icode (w_icode),
    .w_dstE  (w_dstE),
    .w_dstM  (w_dstM),
    .w_valE  (w_valE),
    .w_valM  (w_valM),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .d_rvalA (d_rvalA),
    .d_rvalB (d_rvalB),
    .stat    (stat),
    .halted  (halted),
    .retired (retired)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mread(
    input logic [3:0] a
  );
    return (a == 4'hF) ? 64'd0 : mrf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++)
      mrf[i] = '0;
    mhalt = 1'b0;
    mstat = 3'd1;
    mret  = '0;
  endtask

  // Writes land in slot 15 are discarded by mread
  task automatic model_step();
    if (mhalt) return;
    if (w_stat == 3'd1) begin
      mrf[w_dstE] = w_valE;
      mrf[w_dstM] = w_valM;
      mrf[15] = '0;
    end
    if (w_stat == 3'd1 || w_stat == 3'd2)
      mret = mret + 64'd1;
    if (w_stat >= 3'd2) begin
      mhalt = 1'b1;
      mstat = w_stat;
    end else begin
      mstat = 3'd1;
    end
  endtask

  task automatic cmp_all(input string ph);
    chk({ph, "_rva"}, d_rvalA, mread(d_srcA));
    chk({ph, "_rvb"}, d_rvalB, mread(d_srcB));
    chk({ph, "_stat"}, {61'd0, stat},
        {61'd0, mstat});
    chk({ph, "_halt"}, {63'd0, halted},
        {63'd0, mhalt});
    chk({ph, "_ret"}, retired, mret);
  endtask

  task automatic cyc(
    input logic [2:0]  ws,
    input logic [3:0]  de,
    input logic [3:0]  dm,
    input logic [63:0] ve,
    input logic [63:0] vm,
    input logic [3:0]  sa,
    input logic [3:0]  sb
  );
    w_stat = ws;
    w_dstE = de;
    w_dstM = dm;
    w_valE = ve;
    w_valM = vm;
    d_srcA = sa;
    d_srcB = sb;
    w_icode = 4'($urandom_range(0, 11));
    #1;
    cmp_all("pre");
    @(posedge clk);
    model_step();
    #1;
    cmp_all("post");
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all("rst");
    w_stat = 3'd1;
    w_dstE = 4'd5;
    w_valE = 64'hDEAD;
    d_srcA = 4'd5;
    @(posedge clk);
    #1;
    chk("rst_nowr", d_rvalA, 64'd0);
    w_stat = 3'd0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic rand_cyc();
    int r;
    logic [2:0] ws;
    r = $urandom_range(0, 99);
    if (r < 60)      ws = 3'd1;
    else if (r < 92) ws = 3'd0;
    else if (r < 95) ws = 3'd2;
    else if (r < 98) ws = 3'd3;
    else             ws = 3'd4;
    cyc(ws,
        4'($urandom_range(0, 15)),
        4'($urandom_range(0, 15)),
        {$urandom, $urandom},
        {$urandom, $urandom},
        4'($urandom_range(0, 15)),
        4'($urandom_range(0, 15)));
  endtask

  initial begin
    model_reset();
    #3;
    @(posedge clk);
    #1;
    do_reset();

    cyc(3'd1, 4'd0, 4'hF, 64'h1234, 64'd0,
        4'd0, 4'hF);
    chk("r035_rd", d_rvalA, 64'h1234);
    chk("r035_ret", retired, 64'd1);

    cyc(3'd1, 4'd4, 4'd4, 64'd8, 64'hAA,
        4'd4, 4'hF);
    chk("r036_rd", d_rvalA, 64'hAA);

    cyc(3'd0, 4'd3, 4'hF, 64'd5, 64'd0,
        4'd3, 4'hF);
    chk("r037_rd", d_rvalA, 64'd0);
    chk("r037_ret", retired, 64'd2);
    chk("r037_st", {61'd0, stat}, 64'd1);

    cyc(3'd1, 4'd1, 4'hF, 64'd3, 64'd0,
        4'd1, 4'hF);
    w_dstE = 4'd1;
    w_valE = 64'd7;
    #1;
    chk("r039_pre", d_rvalA, 64'd3);
    cyc(3'd1, 4'd1, 4'hF, 64'd7, 64'd0,
        4'd1, 4'hF);
    chk("r039_post", d_rvalA, 64'd7);

    cyc(3'd3, 4'hF, 4'd2, 64'd0, 64'h99,
        4'd2, 4'hF);
    chk("r038_rd", d_rvalA, 64'd0);
    chk("r038_st", {61'd0, stat}, 64'd3);
    chk("r038_h", {63'd0, halted}, 64'd1);
    chk("r038_ret", retired, 64'd4);
    cyc(3'd1, 4'd2, 4'hF, 64'h55, 64'd0,
        4'd2, 4'd1);
    chk("r038_frz", d_rvalA, 64'd0);
    chk("r038_st2", {61'd0, stat}, 64'd3);

    do_reset();
    chk("r040_st", {61'd0, stat}, 64'd1);
    chk("r040_h", {63'd0, halted}, 64'd0);
    chk("r040_ret", retired, 64'd0);

    cyc(3'd1, 4'd6, 4'hF, 64'h66, 64'd0,
        4'd6, 4'd1);
    chk("r031_rd", d_rvalA, 64'h66);
    chk("r031_rb", d_rvalB, 64'd0);
    chk("r031_ret", retired, 64'd1);

    for (int ep = 0; ep < 6; ep++) begin
      for (int n = 0; n < 60; n++)
        rand_cyc();
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
